// File: rtl/ps2_frame_rx_module.sv
// ps2_frame_rx_module: PS/2 device-to-host frame receiver (start, 8 data LSB-first, odd parity, stop)
// with inter-edge timeout. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module ps2_frame_rx_module #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       H2L_Sig,
    input  logic       PS2_Data_Pin_In,
    input  logic       Rx_En,
    output logic [7:0] Rx_Data,
    output logic       Rx_Done_Sig,
    output logic       Parity_Err_Sig,
    output logic       Frame_Err_Sig,
    output logic       Busy_Sig
);

    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    logic              data_s1_q, data_s2_q;
    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [c_TO_W-1:0] to_q, to_d;
    logic [7:0]        rxd_q, rxd_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              w_timeout;

    // Two-flop alignment stage brings the data line to the same latency as H2L_Sig.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            data_s1_q <= PS2_Data_Pin_In;
            data_s2_q <= data_s1_q;
        end
    end

    // A falling edge in the terminal cycle takes precedence over the timeout.
    assign w_timeout = (state_q != c_IDLE) && !H2L_Sig && (to_q == c_TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        rxd_d   = rxd_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (state_q == c_IDLE || H2L_Sig) begin
            to_d = '0;
        end else begin
            to_d = to_q + c_TO_ONE;
        end

        case (state_q)
            c_IDLE: begin
                if (H2L_Sig && Rx_En && !data_s2_q) begin
                    state_d = c_DATA;
                    cnt_d   = 3'd0;
                end
            end
            c_DATA: begin
                if (H2L_Sig) begin
                    shift_d = {data_s2_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = c_PARITY;
                    end
                end
            end
            c_PARITY: begin
                if (H2L_Sig) begin
                    par_d   = data_s2_q;
                    state_d = c_STOP;
                end
            end
            c_STOP: begin
                if (H2L_Sig) begin
                    state_d = c_IDLE;
                    if (!data_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else begin
                        rxd_d  = shift_q;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (w_timeout) begin
            state_d = c_IDLE;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
            to_d    = '0;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= c_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            to_q    <= '0;
            rxd_q   <= 8'h00;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            to_q    <= to_d;
            rxd_q   <= rxd_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign Rx_Data        = rxd_q;
    assign Rx_Done_Sig    = done_q;
    assign Parity_Err_Sig = perr_q;
    assign Frame_Err_Sig  = ferr_q;
    assign Busy_Sig       = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_rx_module.sv
// tb_ps2_frame_rx_module: directed self-checking bench for the PS/2 frame receiver. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_frame_rx_module;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       H2L_Sig = 1'b0;
    logic       PS2_Data_Pin_In = 1'b1;
    logic       Rx_En = 1'b1;
    logic [7:0] Rx_Data;
    logic       Rx_Done_Sig;
    logic       Parity_Err_Sig;
    logic       Frame_Err_Sig;
    logic       Busy_Sig;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_perr = 0;
    int n_ferr = 0;

    ps2_frame_rx_module #(.TIMEOUT_CYCLES(100)) u_dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .H2L_Sig        (H2L_Sig),
        .PS2_Data_Pin_In(PS2_Data_Pin_In),
        .Rx_En          (Rx_En),
        .Rx_Data        (Rx_Data),
        .Rx_Done_Sig    (Rx_Done_Sig),
        .Parity_Err_Sig (Parity_Err_Sig),
        .Frame_Err_Sig  (Frame_Err_Sig),
        .Busy_Sig       (Busy_Sig)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Rx_Done_Sig)    n_done++;
        if (Parity_Err_Sig) n_perr++;
        if (Frame_Err_Sig)  n_ferr++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One PS/2 bit: data settles through the synchronizer before the edge pulse.
    task automatic send_bit(input logic b);
        PS2_Data_Pin_In = b;
        repeat (3) @(posedge CLK);
        #1;
        H2L_Sig = 1'b1;
        @(posedge CLK);
        #1;
        H2L_Sig = 1'b0;
    endtask

    task automatic send_tail(input logic [7:0] d, input logic par, input logic stop);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        PS2_Data_Pin_In = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        send_tail(d, par, stop);
    endtask

    // Check the cycle after the stop edge, then that every flag drops after one cycle.
    task automatic check_result(input string tag, input logic done, input logic perr,
                                input logic ferr, input logic [7:0] rx);
        @(negedge CLK);
        check_val({tag, ".done"}, Rx_Done_Sig, done);
        check_val({tag, ".perr"}, Parity_Err_Sig, perr);
        check_val({tag, ".ferr"}, Frame_Err_Sig, ferr);
        check_val({tag, ".data"}, Rx_Data, rx);
        check_val({tag, ".busy"}, Busy_Sig, 1'b0);
        @(negedge CLK);
        check_val({tag, ".flags_1cyc"}, {Rx_Done_Sig, Parity_Err_Sig, Frame_Err_Sig}, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0;
        int d0;
        int p0;

        repeat (3) @(negedge CLK);
        check_val("rst.data", Rx_Data, 8'h00);
        check_val("rst.flags", {Rx_Done_Sig, Parity_Err_Sig, Frame_Err_Sig}, 3'b000);
        check_val("rst.busy", Busy_Sig, 1'b0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        send_frame(8'h1C, 1'b0, 1'b1);
        check_result("good_1C", 1'b1, 1'b0, 1'b0, 8'h1C);

        send_frame(8'h1C, 1'b1, 1'b1);
        check_result("perr_1C", 1'b0, 1'b1, 1'b0, 8'h1C);

        send_frame(8'hF0, 1'b1, 1'b0);
        check_result("ferr_F0", 1'b0, 1'b0, 1'b1, 8'h1C);
        send_frame(8'hF0, 1'b1, 1'b1);
        check_result("good_F0", 1'b1, 1'b0, 1'b0, 8'hF0);

        // Timeout: start + 4 data bits, then silence.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        f0 = n_ferr;
        @(negedge CLK);
        check_val("to.busy_mid", Busy_Sig, 1'b1);
        @(posedge CLK);
        #1;
        repeat (98) @(posedge CLK);
        @(negedge CLK);
        check_val("to.no_early_ferr", n_ferr - f0, 0);
        check_val("to.busy_c100", Busy_Sig, 1'b1);
        @(negedge CLK);
        check_val("to.ferr_c101", Frame_Err_Sig, 1'b1);
        check_val("to.busy_after", Busy_Sig, 1'b0);
        check_val("to.data_kept", Rx_Data, 8'hF0);
        @(negedge CLK);
        check_val("to.ferr_1cyc", Frame_Err_Sig, 1'b0);
        PS2_Data_Pin_In = 1'b1;
        @(posedge CLK);
        #1;
        send_frame(8'h5A, 1'b1, 1'b1);
        check_result("good_5A", 1'b1, 1'b0, 1'b0, 8'h5A);

        // Edge arriving exactly on the terminal count keeps the frame alive.
        send_bit(1'b0);
        PS2_Data_Pin_In = 1'b1;
        repeat (99) @(posedge CLK);
        #1;
        H2L_Sig = 1'b1;
        @(posedge CLK);
        #1;
        H2L_Sig = 1'b0;
        for (int i = 1; i < 8; i++) send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        PS2_Data_Pin_In = 1'b1;
        check_result("edge_wins_01", 1'b1, 1'b0, 1'b0, 8'h01);

        // Rx_En low at the start edge: whole frame ignored.
        d0 = n_done; p0 = n_perr; f0 = n_ferr;
        Rx_En = 1'b0;
        send_frame(8'h33, 1'b1, 1'b1);
        repeat (3) @(negedge CLK);
        check_val("en0.no_flags", (n_done - d0) + (n_perr - p0) + (n_ferr - f0), 0);
        check_val("en0.busy", Busy_Sig, 1'b0);
        check_val("en0.data", Rx_Data, 8'h01);
        Rx_En = 1'b1;

        send_bit(1'b1);
        @(negedge CLK);
        check_val("lone1.busy", Busy_Sig, 1'b0);
        repeat (2) @(negedge CLK);
        check_val("lone1.no_flags", (n_done - d0) + (n_perr - p0) + (n_ferr - f0), 0);
        @(posedge CLK);
        #1;

        // Dropping Rx_En after the start bit does not abort the frame.
        send_bit(1'b0);
        Rx_En = 1'b0;
        send_tail(8'h81, 1'b1, 1'b1);
        check_result("en_drop_81", 1'b1, 1'b0, 1'b0, 8'h81);
        Rx_En = 1'b1;

        // Reset after 5 edges.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge CLK);
        check_val("rstmid.busy_before", Busy_Sig, 1'b1);
        d0 = n_done; p0 = n_perr; f0 = n_ferr;
        RSTn = 1'b0;
        #1;
        check_val("rstmid.busy_async", Busy_Sig, 1'b0);
        @(negedge CLK);
        check_val("rstmid.data", Rx_Data, 8'h00);
        check_val("rstmid.flags", {Rx_Done_Sig, Parity_Err_Sig, Frame_Err_Sig}, 3'b000);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        PS2_Data_Pin_In = 1'b1;
        repeat (150) @(negedge CLK);
        check_val("rstmid.no_flags", (n_done - d0) + (n_perr - p0) + (n_ferr - f0), 0);
        check_val("rstmid.busy_after", Busy_Sig, 1'b0);
        @(posedge CLK);
        #1;
        send_frame(8'h29, 1'b0, 1'b1);
        check_result("good_29", 1'b1, 1'b0, 1'b0, 8'h29);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
